// File: rtl/jpc_imem_resp.sv
`default_nettype none
// ============================================================================
// Module      : jpc_imem_resp
// Description : Memory-side responder for the instruction-fetch interface.
//               Accepts read addresses over valid/ready, reads a synchronous
//               single-port BRAM and returns in-order responses over a
//               second valid/ready handshake. Two response slots (the BRAM
//               output itself plus one hold register) sustain one word per
//               cycle under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module jpc_imem_resp #(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int DATA_WIDTH  = 32,
    parameter  int DEPTH       = 256,
    parameter  int WAIT_STATES = 0,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr_I,
    input  logic                  mem_addr_valid_I,
    output logic                  mem_addr_ready_O,
    output logic [DATA_WIDTH-1:0] mem_data_O,
    output logic                  mem_data_valid_O,
    input  logic                  mem_data_ready_I,
    output logic                  mem_err_O,
    output logic [IDX_W-1:0]      bram_addr_O,
    output logic                  bram_en_O,
    input  logic [DATA_WIDTH-1:0] bram_dout_I
);

    // Occupancy states: EMPTY = nothing outstanding, ONE = the BRAM-direct
    // slot owns a read, TWO = hold register is occupied as well (it is always
    // the older of the two responses).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [3:0]            c_wait_load = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] c_depth     = ADDR_WIDTH'(DEPTH);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wait_cnt;
    logic                  r_dir_err;
    logic                  r_hold_err;
    logic [DATA_WIDTH-1:0] r_hold_data;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_addr_err;
    logic                  w_dir_valid;
    logic [DATA_WIDTH-1:0] w_dir_data;
    logic                  w_hold_load;
    logic                  w_hs;

    // Misaligned or beyond-the-array addresses never touch the BRAM.
    assign w_addr_err = (mem_addr_I[1:0] != 2'b00) || ((mem_addr_I >> 2) >= c_depth);

    // Ready depends only on state (never on valid) so the initiator cannot
    // form a combinational loop through us.
    assign w_ready          = rst & (r_state != ST_TWO) & (r_wait_cnt == 4'd0);
    assign mem_addr_ready_O = w_ready;
    assign w_accept         = mem_addr_valid_I & w_ready;

    // The BRAM samples enable/index at the accept edge itself.
    assign bram_en_O   = w_accept & ~w_addr_err;
    assign bram_addr_O = bram_en_O ? mem_addr_I[IDX_W+1:2] : '0;

    // The direct slot presents once any wait states have elapsed; BRAM dout is
    // stable meanwhile because a new enable always evicts it into hold first.
    assign w_dir_valid = (r_state != ST_EMPTY) && (r_wait_cnt == 4'd0);
    assign w_dir_data  = r_dir_err ? '0 : bram_dout_I;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and response output selection (oldest response first).
    always_comb begin
        w_state_nxt      = r_state;
        w_hold_load      = 1'b0;
        w_hs             = 1'b0;
        mem_data_valid_O = 1'b0;
        mem_data_O       = '0;
        mem_err_O        = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                mem_data_valid_O = w_dir_valid;
                if (w_dir_valid) begin
                    mem_data_O = w_dir_data;
                    mem_err_O  = r_dir_err;
                end
                w_hs = w_dir_valid & mem_data_ready_I;
                if (w_accept && !w_hs) begin
                    // Accept implies wait_cnt==0, so the direct slot is live
                    // and must be parked before the BRAM overwrites it.
                    w_state_nxt = ST_TWO;
                    w_hold_load = 1'b1;
                end else if (w_hs && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                mem_data_valid_O = 1'b1;
                mem_data_O       = r_hold_data;
                mem_err_O        = r_hold_err;
                w_hs             = mem_data_ready_I;
                if (w_hs) begin
                    w_state_nxt = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Per-read bookkeeping for the direct slot: error flag and wait countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 4'd0;
            r_dir_err  <= 1'b0;
        end else if (w_accept) begin
            r_wait_cnt <= c_wait_load;
            r_dir_err  <= w_addr_err;
        end else if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // Hold register captures the direct slot when a newer read displaces it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_data <= '0;
            r_hold_err  <= 1'b0;
        end else if (w_hold_load) begin
            r_hold_data <= w_dir_data;
            r_hold_err  <= r_dir_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jpc_imem_resp.sv
`default_nettype none
// Bench for jpc_imem_resp: one instance with no wait states driven by directed
// and random traffic against a response-queue model, one instance with two
// wait states exercised with directed latency and mid-wait reset steps.
module tb_jpc_imem_resp;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic [31:0] mem [256];

    // Instance 0 (WAIT_STATES = 0)
    logic        rst0;
    logic [31:0] addr0;
    logic        av0, ar0, dv0, dr0, err0, en0;
    logic [31:0] data0, dout0;
    logic [7:0]  baddr0;

    // Instance 1 (WAIT_STATES = 2)
    logic        rst1;
    logic [31:0] addr1;
    logic        av1, ar1, dv1, dr1, err1, en1;
    logic [31:0] data1, dout1;
    logic [7:0]  baddr1;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t q[$];

    always #5 clk = ~clk;

    jpc_imem_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst0),
        .mem_addr_I(addr0), .mem_addr_valid_I(av0), .mem_addr_ready_O(ar0),
        .mem_data_O(data0), .mem_data_valid_O(dv0), .mem_data_ready_I(dr0),
        .mem_err_O(err0), .bram_addr_O(baddr0), .bram_en_O(en0), .bram_dout_I(dout0)
    );

    jpc_imem_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) u_dut1 (
        .clk(clk), .rst(rst1),
        .mem_addr_I(addr1), .mem_addr_valid_I(av1), .mem_addr_ready_O(ar1),
        .mem_data_O(data1), .mem_data_valid_O(dv1), .mem_data_ready_I(dr1),
        .mem_err_O(err1), .bram_addr_O(baddr1), .bram_en_O(en1), .bram_dout_I(dout1)
    );

    // Synchronous BRAM models: dout updates only on an enabled edge.
    always @(posedge clk) if (en0) dout0 <= mem[baddr0];
    always @(posedge clk) if (en1) dout1 <= mem[baddr1];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd1024);
    endfunction

    function automatic resp_t ref_resp(input logic [31:0] a);
        resp_t r;
        if (ref_err(a)) begin
            r.data = 32'h0;
            r.err  = 1'b1;
        end else begin
            r.data = mem[a[9:2]];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // One cycle on instance 0, entered and left at a falling edge. Expected
    // outputs come from the queue of outstanding responses (accepted, not yet
    // handed over); with no wait states every queued response is presentable.
    task automatic tick(input logic av, input logic [31:0] a, input logic dr);
        logic acc, hs;
        av0 = av; addr0 = a; dr0 = dr;
        #1;
        acc = av && (q.size() < 2);
        hs  = (q.size() != 0) && dr;
        chk1("addr_ready", ar0, q.size() < 2);
        chk1("data_valid", dv0, q.size() != 0);
        if (q.size() != 0) begin
            chk32("data", data0, q[0].data);
            chk1("err", err0, q[0].err);
        end else begin
            chk32("idle_data", data0, 32'h0);
            chk1("idle_err", err0, 1'b0);
        end
        chk1("bram_en", en0, acc && !ref_err(a));
        if (acc && !ref_err(a)) chk32("bram_addr", 32'(baddr0), 32'(a[9:2]));
        @(posedge clk);
        if (hs)  void'(q.pop_front());
        if (acc) q.push_back(ref_resp(a));
        @(negedge clk);
    endtask

    // Asynchronous reset pulse on instance 0 asserted mid-cycle.
    task automatic reset0();
        av0 = 1'b0; dr0 = 1'b0;
        rst0 = 1'b0;
        #1;
        chk1("rst_ready", ar0, 1'b0);
        chk1("rst_valid", dv0, 1'b0);
        chk1("rst_err", err0, 1'b0);
        chk32("rst_data", data0, 32'h0);
        chk1("rst_bram_en", en0, 1'b0);
        chk32("rst_bram_addr", 32'(baddr0), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        q.delete();
    endtask

    // Single read on instance 1: latency must equal the two wait states.
    task automatic ws_read(input logic [31:0] a, input logic [31:0] ed, input logic ee);
        int n;
        av1 = 1'b1; addr1 = a; dr1 = 1'b1;
        #1;
        chk1("ws_ready_idle", ar1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        av1 = 1'b0;
        n = 0;
        while (n < 20) begin
            #1;
            if (dv1) break;
            chk1("ws_ready_wait", ar1, 1'b0);
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        chk32("ws_latency", 32'(n), 32'd2);
        chk32("ws_data", data1, ed);
        chk1("ws_err", err1, ee);
        chk1("ws_ready_done", ar1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk1("ws_valid_after", dv1, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout: checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic        rv, rr, stalled;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h00000013;
        mem[2] = 32'hCAFEF00D;

        rst0 = 1'b0; av0 = 1'b0; addr0 = 32'h0; dr0 = 1'b0;
        rst1 = 1'b0; av1 = 1'b0; addr1 = 32'h0; dr1 = 1'b0;

        // T1: reset state, then release
        @(negedge clk);
        #1;
        chk1("t1_ready_in_rst", ar0, 1'b0);
        chk1("t1_valid_in_rst", dv0, 1'b0);
        chk32("t1_data_in_rst", data0, 32'h0);
        chk1("t1_ws_ready_in_rst", ar1, 1'b0);
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1;
        tick(1'b0, 32'h0, 1'b0);

        // T2: single read
        tick(1'b1, 32'h0, 1'b1);
        chk32("t2_data_const", data0, 32'hDEADBEEF);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);

        // T3: streaming three words
        tick(1'b1, 32'h0, 1'b1);
        tick(1'b1, 32'h4, 1'b1);
        tick(1'b1, 32'h8, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);

        // T4: backpressure with a stalled third address
        tick(1'b1, 32'h0, 1'b0);
        tick(1'b1, 32'h4, 1'b0);
        chk1("t4_ready_full", ar0, 1'b0);
        chk32("t4_hold_const", data0, 32'hDEADBEEF);
        tick(1'b1, 32'h8, 1'b0);
        tick(1'b1, 32'h8, 1'b0);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);

        // T5: error addresses, last valid word, interleaved ordering
        tick(1'b1, 32'h2, 1'b1);
        chk1("t5_err_misaligned", err0, 1'b1);
        chk32("t5_err_data", data0, 32'h0);
        tick(1'b1, 32'h400, 1'b1);
        chk1("t5_err_range", err0, 1'b1);
        tick(1'b1, 32'h3FC, 1'b1);
        tick(1'b1, 32'h0, 1'b0);
        tick(1'b1, 32'h2, 1'b0);
        tick(1'b1, 32'h4, 1'b1);
        tick(1'b1, 32'h4, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);

        // Random traffic with a reset pulse in the middle
        rv = 1'b0; ra = 32'h0; stalled = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset0();
                stalled = 1'b0;
            end
            if (stalled) begin
                rv = ($urandom % 8) != 0;
            end else begin
                rv = ($urandom % 4) != 0;
                case ($urandom % 8)
                    0:       ra = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
                    1:       ra = 32'h400 + ($urandom_range(0, 255) << 2);
                    2:       ra = $urandom;
                    default: ra = $urandom_range(0, 255) << 2;
                endcase
            end
            rr = ($urandom % 3) != 0;
            stalled = rv && (q.size() >= 2);
            tick(rv, ra, rr);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b1);

        // T6: wait states on instance 1
        ws_read(32'h4, 32'h00000013, 1'b0);
        ws_read(32'h2, 32'h0, 1'b1);

        // T6: reset pulse while waiting discards the read
        av1 = 1'b1; addr1 = 32'h4; dr1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        av1 = 1'b0;
        #1;
        chk1("t6_ready_wait", ar1, 1'b0);
        rst1 = 1'b0;
        #1;
        chk1("t6_valid_in_rst", dv1, 1'b0);
        chk1("t6_ready_in_rst", ar1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("t6_no_spurious_valid", dv1, 1'b0);
            chk1("t6_ready_after_rst", ar1, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
